// File: rtl/phase_synth_pkg.sv
// Shared phase-vocoder constants (common with the analysis side) and the
// synthesizer's state encoding.
package phase_synth_pkg;

  localparam int DEF_PHASE_WIDTH = 24;
  localparam int DEF_PHASE_FRAC  = 21;
  localparam int DEF_K_WIDTH     = 11;
  localparam int DEF_HOP_SHIFT   = 2;

  // round(2*pi*2^21) and round(2^21/(2*pi)), unsigned
  localparam logic [DEF_PHASE_WIDTH-1:0] DEF_TWO_PI_Q = 24'hC90FDB;
  localparam logic [DEF_PHASE_WIDTH-1:0] DEF_INV_2PI  = 24'h0517CC;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

endpackage

// File: rtl/phase_synthesizer_ram.sv
// Per-bin phase accumulator store: one write port, one registered read port.
// A read and write to the same address on one edge return the old contents.
module phase_acc_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 21
) (
  input  logic              clock,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    o_rdData <= r_mem[i_rdAddr];
  end

endmodule

// File: rtl/phase_synthesizer.sv
// Phase-vocoder synthesis: accumulates per-bin phase increments across frames
// and emits the wrapped phase in radians, 4-cycle latency, 1 bin per cycle.
module phase_synthesizer
  import phase_synth_pkg::*;
#(
  parameter int                     PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int                     PHASE_FRAC  = DEF_PHASE_FRAC,
  parameter int                     K_WIDTH     = DEF_K_WIDTH,
  parameter int                     HOP_SHIFT   = DEF_HOP_SHIFT,
  parameter logic [PHASE_WIDTH-1:0] TWO_PI_Q    = DEF_TWO_PI_Q
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  output logic                          ready,
  input  logic [K_WIDTH-1:0]            k,
  input  logic [K_WIDTH+PHASE_FRAC-1:0] freq,
  input  logic                          in_valid,
  output logic [PHASE_WIDTH-1:0]        phase_out,
  output logic [K_WIDTH-1:0]            k_out,
  output logic                          out_valid
);

  localparam int FREQ_W = K_WIDTH + PHASE_FRAC;
  localparam int PROD_W = PHASE_FRAC + PHASE_WIDTH;
  localparam logic [K_WIDTH-1:0] LAST_ADDR = '1;

  state_t              r_state, w_stateNext;
  logic [K_WIDTH-1:0]  r_clrAddr, w_clrAddrNext;
  logic                w_accept;

  logic [FREQ_W-1:0]     w_turns;
  logic                  w_unusedTurnBits;
  logic [PHASE_FRAC-1:0] w_incr;

  logic                  r_v0, r_v1, r_v2, r_v3;
  logic [K_WIDTH-1:0]    r_k0, r_k1, r_k2, r_k3;
  logic [PHASE_FRAC-1:0] r_inc0, r_inc1;
  logic [PHASE_FRAC-1:0] r_acc2, r_acc3;
  logic [PHASE_FRAC-1:0] w_ramRd, w_accOld, w_accNew;
  logic [PHASE_WIDTH-1:0] r_prod3;

  logic [PROD_W-1:0]      w_accExt, w_twoPiExt, w_prod;
  logic [PHASE_WIDTH-1:0] w_prodHi;
  logic [PHASE_FRAC-1:0]  w_unusedProdLsbs;

  logic                  w_wrEn;
  logic [K_WIDTH-1:0]    w_wrAddr;
  logic [PHASE_FRAC-1:0] w_wrData;

  assign ready    = (r_state == ST_RUN);
  assign w_accept = in_valid && ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clrAddr <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_clrAddr <= w_clrAddrNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_clrAddrNext = r_clrAddr;
    case (r_state)
      ST_CLEAR: begin
        if (clear) begin
          w_clrAddrNext = '0;
        end else begin
          w_clrAddrNext = r_clrAddr + 1'b1;
          if (r_clrAddr == LAST_ADDR) w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear) begin
          w_stateNext   = ST_CLEAR;
          w_clrAddrNext = '0;
        end
      end
      default: begin
        w_stateNext   = ST_CLEAR;
        w_clrAddrNext = '0;
      end
    endcase
  end

  // Only the fractional turns of freq >> HOP_SHIFT matter; whole turns vanish.
  assign w_turns          = freq >> HOP_SHIFT;
  assign w_incr           = w_turns[PHASE_FRAC-1:0];
  assign w_unusedTurnBits = ^w_turns[FREQ_W-1:PHASE_FRAC];

  // The sweep owns the write port while clearing; in-flight write-backs are dropped.
  assign w_wrEn   = (r_state == ST_CLEAR) ? 1'b1 : r_v2;
  assign w_wrAddr = (r_state == ST_CLEAR) ? r_clrAddr : r_k2;
  assign w_wrData = (r_state == ST_CLEAR) ? '0 : r_acc2;

  phase_acc_ram #(
    .ADDR_W (K_WIDTH),
    .DATA_W (PHASE_FRAC)
  ) u_ram (
    .clock    (clock),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (w_wrAddr),
    .i_wrData (w_wrData),
    .i_rdAddr (r_k0),
    .o_rdData (w_ramRd)
  );

  // S2 has not written yet and S3 wrote on the same edge the RAM was read,
  // so both are newer than the RAM word; S2 is the younger and wins.
  always_comb begin
    w_accOld = w_ramRd;
    if (r_v2 && (r_k2 == r_k1))      w_accOld = r_acc2;
    else if (r_v3 && (r_k3 == r_k1)) w_accOld = r_acc3;
  end

  assign w_accNew   = w_accOld + r_inc1;
  assign w_accExt   = {{(PROD_W-PHASE_FRAC){r_acc2[PHASE_FRAC-1]}}, r_acc2};
  assign w_twoPiExt = {{(PROD_W-PHASE_WIDTH){1'b0}}, TWO_PI_Q};
  assign w_prod     = w_accExt * w_twoPiExt;
  assign {w_prodHi, w_unusedProdLsbs} = w_prod;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_k0      <= '0;
      r_k1      <= '0;
      r_k2      <= '0;
      r_k3      <= '0;
      r_inc0    <= '0;
      r_inc1    <= '0;
      r_acc2    <= '0;
      r_acc3    <= '0;
      r_prod3   <= '0;
      out_valid <= 1'b0;
      k_out     <= '0;
      phase_out <= '0;
    end else begin
      r_v0      <= w_accept;
      r_k0      <= k;
      r_inc0    <= w_incr;
      r_v1      <= r_v0;
      r_k1      <= r_k0;
      r_inc1    <= r_inc0;
      r_v2      <= r_v1;
      r_k2      <= r_k1;
      r_acc2    <= w_accNew;
      r_v3      <= r_v2;
      r_k3      <= r_k2;
      r_acc3    <= r_acc2;
      r_prod3   <= w_prodHi;
      out_valid <= r_v3;
      k_out     <= r_k3;
      phase_out <= r_prod3;
    end
  end

endmodule

// File: tb/tb_phase_synthesizer.sv
// Directed bench for phase_synthesizer: clear sweep timing, accumulation,
// forwarding, wrap/integer-discard and clear-with-beats-in-flight.
module tb_phase_synthesizer;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        ready;
  logic [10:0] k;
  logic [31:0] freq;
  logic        in_valid;
  logic [23:0] phase_out;
  logic [10:0] k_out;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  logic [10:0] obsK[$];
  logic [23:0] obsPh[$];

  phase_synthesizer dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .ready     (ready),
    .k         (k),
    .freq      (freq),
    .in_valid  (in_valid),
    .phase_out (phase_out),
    .k_out     (k_out),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (out_valid) begin
      obsK.push_back(k_out);
      obsPh.push_back(phase_out);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [10:0] kk, input logic [31:0] ff);
    k        = kk;
    freq     = ff;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic expectOut(input string tag, input logic [10:0] expK, input logic [23:0] expPh);
    int waited = 0;
    logic [10:0] gotK;
    logic [23:0] gotPh;
    while (obsK.size() == 0 && waited < 16) begin
      @(negedge clock);
      waited++;
    end
    if (obsK.size() == 0) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      gotK  = obsK.pop_front();
      gotPh = obsPh.pop_front();
      checkOutput({tag, "_k"}, 32'(gotK), 32'(expK));
      checkOutput({tag, "_phase"}, 32'(gotPh), 32'(expPh));
    end
  endtask

  // Counts ready=0 cycles from the current negedge on, bounded.
  task automatic countClearCycles(output int cycles, output logic sawValid);
    cycles   = 0;
    sawValid = 1'b0;
    while (!ready && cycles < 5000) begin
      if (out_valid) sawValid = 1'b1;
      @(negedge clock);
      cycles++;
    end
  endtask

  initial begin
    int   cycles;
    logic sawValid;
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    k        = '0;
    freq     = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_phase", 32'(phase_out), 32'd0);
    checkOutput("rst_k_out", 32'(k_out), 32'd0);

    reset = 1'b0;
    countClearCycles(cycles, sawValid);
    checkOutput("rst_sweep_cycles", 32'(cycles), 32'd2048);
    checkOutput("rst_sweep_no_valid", 32'(sawValid), 32'd0);
    checkOutput("rst_ready_after", 32'(ready), 32'd1);

    // 5.0 bins -> 1.25 turns per hop -> pi/2, then -pi
    applyStimulus(11'd5, 32'h00A0_0000);
    repeat (3) @(negedge clock);
    checkOutput("latency_early", 32'(out_valid), 32'd0);
    @(negedge clock);
    checkOutput("latency_valid", 32'(out_valid), 32'd1);
    expectOut("k5_f1", 11'd5, 24'h3243F6);
    applyStimulus(11'd5, 32'h00A0_0000);
    expectOut("k5_f2", 11'd5, 24'h9B7812);

    // back-to-back same bin, 1/16 turn each
    applyStimulus(11'd7, 32'h0008_0000);
    applyStimulus(11'd7, 32'h0008_0000);
    applyStimulus(11'd7, 32'h0008_0000);
    expectOut("fwd_1", 11'd7, 24'h0C90FD);
    expectOut("fwd_2", 11'd7, 24'h1921FB);
    expectOut("fwd_3", 11'd7, 24'h25B2F9);

    // interleaved bins: k1 +1/4 turn, k2 +1/8 turn
    applyStimulus(11'd1, 32'h0020_0000);
    applyStimulus(11'd2, 32'h0010_0000);
    applyStimulus(11'd1, 32'h0020_0000);
    applyStimulus(11'd2, 32'h0010_0000);
    expectOut("intl_k1a", 11'd1, 24'h3243F6);
    expectOut("intl_k2a", 11'd2, 24'h1921FB);
    expectOut("intl_k1b", 11'd1, 24'h9B7812);
    expectOut("intl_k2b", 11'd2, 24'h3243F6);

    applyStimulus(11'd5, 32'h0000_0000);
    expectOut("freq_zero", 11'd5, 24'h9B7812);

    // large integer parts: 1021 bins -> 0.25 turn, 1023.25 bins -> 0.8125 turn
    applyStimulus(11'd9, 32'h7FA0_0000);
    expectOut("int_discard", 11'd9, 24'h3243F6);
    applyStimulus(11'd10, 32'h7FE8_0000);
    expectOut("int_neg_wrap", 11'd10, 24'hDA4D06);

    // clear with three beats in flight
    applyStimulus(11'd5, 32'h0020_0000);
    applyStimulus(11'd7, 32'h0020_0000);
    applyStimulus(11'd9, 32'h0020_0000);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    countClearCycles(cycles, sawValid);
    checkOutput("clr_sweep_cycles", 32'(cycles), 32'd2048);
    checkOutput("clr_inflight_seen", 32'(sawValid), 32'd1);
    expectOut("clr_fly_k5", 11'd5, 24'hCDBC09);
    expectOut("clr_fly_k7", 11'd7, 24'h57F6EF);
    expectOut("clr_fly_k9", 11'd9, 24'h9B7812);

    applyStimulus(11'd5, 32'h0020_0000);
    applyStimulus(11'd7, 32'h0008_0000);
    expectOut("post_clr_k5", 11'd5, 24'h3243F6);
    expectOut("post_clr_k7", 11'd7, 24'h0C90FD);

    repeat (8) @(negedge clock);
    checkOutput("no_extra_outputs", 32'(obsK.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
